i2c_touch_responder: RTL

I2C target that answers the touch-register reads issued by the touch-panel I2C controller. It presents a coherent snapshot of two touch points, the touch count and the gesture code as a small byte-addressed register file. It sits on the FPGA side of the I2C bus. It is used either as a loopback model of the touch panel in system simulation or to export touch data to an external I2C host.

---
 rtl/touch_resp_pkg.sv | 72 +++++++
 rtl/i2c_bus_sync.sv | 61 ++++++
 rtl/i2c_touch_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/touch_resp_pkg.sv
// touch_resp_pkg
//   Shared types and constants for the I2C touch responder:
//   - state_t   : responder FSM states
//   - snap_t    : shadow copy of one touch sample
//   - REG_*     : register index constants (REG_LAST is the last mapped index)
//   - ACK_BIT / NACK_BIT : SDA level of an acknowledge / not-acknowledge
//   - reg_byte  : register-file read mux
//   - next_ptr  : auto-increment with wrap (0x9 -> 0x0, 0xF -> 0x0)
package touch_resp_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    TX        = 4'd7,
    TX_ACK    = 4'd8
  } state_t;

  typedef struct packed {
    logic [9:0] x1;
    logic [8:0] y1;
    logic [9:0] x2;
    logic [8:0] y2;
    logic [1:0] count;
    logic [7:0] gesture;
  } snap_t;

  localparam logic [3:0] REG_GESTURE = 4'h0;
  localparam logic [3:0] REG_COUNT   = 4'h1;
  localparam logic [3:0] REG_X1_HI   = 4'h2;
  localparam logic [3:0] REG_X1_LO   = 4'h3;
  localparam logic [3:0] REG_Y1_HI   = 4'h4;
  localparam logic [3:0] REG_Y1_LO   = 4'h5;
  localparam logic [3:0] REG_X2_HI   = 4'h6;
  localparam logic [3:0] REG_X2_LO   = 4'h7;
  localparam logic [3:0] REG_Y2_HI   = 4'h8;
  localparam logic [3:0] REG_Y2_LO   = 4'h9;
  localparam logic [3:0] REG_LAST    = 4'h9;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  function automatic logic [7:0] reg_byte(input logic [3:0] idx, input snap_t s);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      REG_GESTURE: b = s.gesture;
      REG_COUNT:   b = {6'b0, s.count};
      REG_X1_HI:   b = {6'b0, s.x1[9:8]};
      REG_X1_LO:   b = s.x1[7:0];
      REG_Y1_HI:   b = {7'b0, s.y1[8]};
      REG_Y1_LO:   b = s.y1[7:0];
      REG_X2_HI:   b = {6'b0, s.x2[9:8]};
      REG_X2_LO:   b = s.x2[7:0];
      REG_Y2_HI:   b = {7'b0, s.y2[8]};
      REG_Y2_LO:   b = s.y2[7:0];
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

  // Mapped range wraps at REG_LAST; the unmapped range 0xA-0xF walks up and
  // wraps through the natural 4-bit overflow.
  function automatic logic [3:0] next_ptr(input logic [3:0] p);
    return (p == REG_LAST) ? 4'h0 : p + 4'h1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync
//   Brings SCL/SDA into the iCLK domain through SYNC_STAGES flops, then one
//   edge-detect flop per line holds the previous synchronized level.
//   Ports:
//     iCLK, iRST           : system clock, synchronous active-high reset
//     scl_in, sda_in       : raw bus levels
//     sda                  : synchronized SDA level (data sampling)
//     scl_rise, scl_fall   : one-cycle SCL edge pulses
//     start_det, stop_det  : one-cycle START / STOP condition pulses
//   Lines reset to 1 (idle bus) so leaving reset never fakes a condition.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl;

  assign scl = scl_sync_q[SYNC_STAGES-1];
  assign sda = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = scl;
    sda_prev_d = sda;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise  = scl & ~scl_prev_q;
  assign scl_fall  = ~scl & scl_prev_q;
  // Conditions only count while SCL stayed high across the SDA change.
  assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/i2c_touch_responder.sv
// i2c_touch_responder
//   I2C target exposing a coherent snapshot of two touch points, the touch
//   count and the gesture code as a 16-entry byte register file.
//   Parameters: I2C_ADDR (7-bit target address), SYNC_STAGES (>=2).
//   Ports:
//     iCLK, iRST          : system clock (>=20x SCL), synchronous active-high reset
//     iREG_*              : live touch inputs, iNEW marks a fresh sample
//     oBUSY               : high from matched address until STOP / unmatched address
//     oRD_DONE            : one-cycle pulse when the host NACKs a read byte
//     oINT_N              : active-low data-ready interrupt
//     oDBG_STATE          : current FSM state
//     I2C_SCLK, I2C_SDAT  : bus; SDA is open-drain (0 or Z only)
//   Build option: define TOUCH_RESP_INT_EN to build the interrupt logic;
//   otherwise oINT_N is tied high.
//   Bus protocol: bits are sampled on the detected SCL rise; SDA drive
//   changes one iCLK after the detected SCL fall; START/STOP win over edges.
module i2c_touch_responder
  import touch_resp_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h38,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [9:0] iREG_X1,
  input  logic [8:0] iREG_Y1,
  input  logic [9:0] iREG_X2,
  input  logic [8:0] iREG_Y2,
  input  logic [1:0] iREG_TOUCH_COUNT,
  input  logic [7:0] iREG_GESTURE,
  input  logic       iNEW,
  output logic       oBUSY,
  output logic       oRD_DONE,
  output logic       oINT_N,
  output state_t     oDBG_STATE,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .scl_in    (I2C_SCLK),
    .sda_in    (I2C_SDAT),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;       // bits shifted in/out of the current byte
  logic [7:0] shift_q, shift_d;   // received byte
  logic [6:0] tx_q, tx_d;         // remaining transmit bits, next one at [6]
  logic [3:0] ptr_q, ptr_d;
  snap_t      shadow_q, shadow_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rd_done_q, rd_done_d;
  logic       snap_now;
  snap_t      live;
  logic [7:0] cur_byte;

  assign live = '{x1: iREG_X1, y1: iREG_Y1, x2: iREG_X2, y2: iREG_Y2,
                  count: iREG_TOUCH_COUNT, gesture: iREG_GESTURE};
  assign cur_byte = reg_byte(ptr_q, shadow_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rd_done_d = 1'b0;
    snap_now  = 1'b0;

    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == I2C_ADDR) begin
                state_d  = ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                snap_now = shift_q[0];
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else if (state_q == PTR) begin
              state_d  = PTR_ACK;
              sda_oe_d = 1'b1;
              ptr_d    = shift_q[3:0];
            end else begin
              state_d  = WDATA_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d  = TX;
              tx_d     = cur_byte[6:0];
              sda_oe_d = ~cur_byte[7];
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d  = WDATA;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
          end
        end
        TX: begin
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = TX_ACK;
              sda_oe_d = 1'b0;
              ptr_d    = next_ptr(ptr_q);
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          // The host's ACK bit is sampled on the rise; a NACK ends the read
          // there, so a fall in this state always follows an ACK.
          if (scl_rise && sda_s == NACK_BIT) begin
            state_d   = IDLE;
            rd_done_d = 1'b1;
          end else if (scl_fall) begin
            state_d  = TX;
            cnt_d    = 4'd0;
            tx_d     = cur_byte[6:0];
            sda_oe_d = ~cur_byte[7];
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Copying the live inputs makes an iNEW in this same cycle land in the
    // snapshot.
    shadow_d = snap_now ? live : shadow_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 8'h00;
      tx_q      <= 7'h00;
      ptr_q     <= 4'h0;
      shadow_q  <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      shadow_q  <= shadow_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rd_done_q <= rd_done_d;
    end
  end

  assign I2C_SDAT   = sda_oe_q ? 1'b0 : 1'bz;
  assign oBUSY      = busy_q;
  assign oRD_DONE   = rd_done_q;
  assign oDBG_STATE = state_q;

`ifdef TOUCH_RESP_INT_EN
  logic int_n_q, int_n_d;

  // A new sample outranks the clear from a read-address ACK.
  always_comb begin
    int_n_d = int_n_q;
    if (snap_now) int_n_d = 1'b1;
    if (iNEW)     int_n_d = 1'b0;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) int_n_q <= 1'b1;
    else      int_n_q <= int_n_d;
  end

  assign oINT_N = int_n_q;
`else
  logic unused_new;
  assign unused_new = iNEW;
  assign oINT_N     = 1'b1;
`endif

endmodule
